coffee_vending: RTL and testbench

- Coin-operated coffee vending controller: accepts 100-won coins on `w100`, and dispenses on a purchase button `btn`.
- Tracks inserted credit in 100-won units.
- Asserts `sale` when a cup is dispensed and `ret` for each 100-won unit refunded or given as change.
- Leaf control block between the coin acceptor / button front-end and the dispenser / coin-return actuators.

---
 rtl/coffee_pkg.sv | 31 +++
 rtl/coffee_vending_if.sv | 28 ++
 rtl/coffee_vending.sv | 113 +++++++++++
 tb/tb_coffee_vending.sv | 139 +++++++++++++
 4 files changed

// File: rtl/coffee_pkg.sv
// Shared definitions for the coffee vending controller.
//   state_e               : controller states (ACCEPT collects coins, RETURN pays out
//                           change longer than one unit).
//   COIN_UNIT_WON         : value of one accepted coin.
//   DEFAULT_PRICE_UNITS   : default cup price in coin units.
//   DEFAULT_MAX_UNITS     : default credit ceiling in coin units.
//   owed_units()          : units to pay back when the button is pressed.
package coffee_pkg;

    typedef enum logic {
        ACCEPT = 1'b0,
        RETURN = 1'b1
    } state_e;

    localparam int unsigned COIN_UNIT_WON       = 32'd100;
    localparam int unsigned DEFAULT_PRICE_UNITS = 32'd2;
    localparam int unsigned DEFAULT_MAX_UNITS   = 32'd3;

    // Underpayment is refunded in full; otherwise only the surplus comes back.
    function automatic int unsigned owed_units(input int unsigned credit,
                                               input int unsigned price);
        int unsigned owed;
        if (credit >= price) begin
            owed = credit - price;
        end else begin
            owed = credit;
        end
        return owed;
    endfunction

endpackage

// File: rtl/coffee_vending_if.sv
// Coin acceptor / button / actuator bundle of the coffee vending controller.
//   w100 : coin strobe, one 100-won coin per high cycle (front-end -> controller)
//   btn  : purchase / return request, level-sampled (front-end -> controller)
//   ret  : one-cycle pulse per returned coin unit (controller -> actuators)
//   sale : one-cycle pulse per dispensed cup (controller -> actuators)
// master = front-end / environment side, slave = controller side.
interface coffee_vending_if;

    logic w100;
    logic btn;
    logic ret;
    logic sale;

    modport master (
        output w100,
        output btn,
        input  ret,
        input  sale
    );

    modport slave (
        input  w100,
        input  btn,
        output ret,
        output sale
    );

endinterface

// File: rtl/coffee_vending.sv
// Coffee vending controller: counts 100-won coins up to MAX_UNITS, and on a button
// press either dispenses a cup (sale) with change, or refunds an underpayment.
// Every returned unit is one ret-high cycle; payouts longer than one unit are
// finished in the RETURN state, which ignores coins and button presses.
// Ports:
//   CLK  : clock, all state changes on the rising edge
//   RSTn : synchronous active-low reset, priority over everything
//   bus  : coffee_vending_if.slave (w100, btn in; ret, sale registered out)
module coffee_vending
    import coffee_pkg::*;
#(
    parameter int unsigned PRICE_UNITS = DEFAULT_PRICE_UNITS,
    parameter int unsigned MAX_UNITS   = DEFAULT_MAX_UNITS
) (
    input  logic                CLK,
    input  logic                RSTn,
    coffee_vending_if.slave     bus
);

    localparam int unsigned CW = $clog2(MAX_UNITS + 32'd1);

    localparam logic [CW-1:0] PRICE_C = CW'(PRICE_UNITS);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_UNITS);
    localparam logic [CW-1:0] ZERO_C  = CW'(32'd0);
    localparam logic [CW-1:0] ONE_C   = CW'(32'd1);

    state_e          state_q, state_d;
    logic [CW-1:0]   credit_q, credit_d;
    logic [CW-1:0]   pend_q, pend_d;
    logic            ret_q, ret_d;
    logic            sale_q, sale_d;
    logic [CW-1:0]   owed_s;

    // Units owed back if the button is pressed with the current credit.
    always_comb begin
        owed_s = CW'(owed_units(32'(credit_q), PRICE_UNITS));
    end

    // Next-state and output decode for the coin/button FSM.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        pend_d   = pend_q;
        ret_d    = 1'b0;
        sale_d   = 1'b0;

        case (state_q)
            ACCEPT: begin
                if (bus.btn) begin
                    // A coin arriving with the button is rejected by the acceptor.
                    if (credit_q == ZERO_C) begin
                        credit_d = ZERO_C;
                    end else begin
                        credit_d = ZERO_C;
                        sale_d   = (credit_q >= PRICE_C);
                        ret_d    = (owed_s != ZERO_C);
                        // First unit goes out now; the rest is paid in RETURN.
                        if (owed_s > ONE_C) begin
                            pend_d  = owed_s - ONE_C;
                            state_d = RETURN;
                        end else begin
                            pend_d  = ZERO_C;
                        end
                    end
                end else if (bus.w100) begin
                    if (credit_q < MAX_C) begin
                        credit_d = credit_q + ONE_C;
                    end else begin
                        credit_d = credit_q;
                    end
                end else begin
                    credit_d = credit_q;
                end
            end
            RETURN: begin
                ret_d  = 1'b1;
                pend_d = pend_q - ONE_C;
                if (pend_q <= ONE_C) begin
                    pend_d  = ZERO_C;
                    state_d = ACCEPT;
                end else begin
                    state_d = RETURN;
                end
            end
            default: begin
                state_d  = ACCEPT;
                credit_d = ZERO_C;
                pend_d   = ZERO_C;
            end
        endcase
    end

    // State, credit, pending-return and registered output flops.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q  <= ACCEPT;
            credit_q <= ZERO_C;
            pend_q   <= ZERO_C;
            ret_q    <= 1'b0;
            sale_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            pend_q   <= pend_d;
            ret_q    <= ret_d;
            sale_q   <= sale_d;
        end
    end

    assign bus.ret  = ret_q;
    assign bus.sale = sale_q;

endmodule

// File: tb/tb_coffee_vending.sv
// Directed bench for coffee_vending. Instance u_dut uses the default pricing
// (200 won, ceiling 300 won); u_dut2 uses PRICE_UNITS=2, MAX_UNITS=5 so that
// multi-unit change through the RETURN state can be exercised.
module tb_coffee_vending;

    logic CLK;
    logic RSTn;

    int checks;
    int errors;

    coffee_vending_if if1 ();
    coffee_vending_if if2 ();

    coffee_vending u_dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (if1.slave)
    );

    coffee_vending #(
        .PRICE_UNITS (2),
        .MAX_UNITS   (5)
    ) u_dut2 (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (if2.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive the default instance for one rising edge, then settle past it.
    task automatic step1(input logic w, input logic b);
        if1.w100 = w;
        if1.btn  = b;
        @(posedge CLK);
        #1;
    endtask

    // Drive the second instance for one rising edge, then settle past it.
    task automatic step2(input logic w, input logic b);
        if2.w100 = w;
        if2.btn  = b;
        @(posedge CLK);
        #1;
    endtask

    // Compare {ret,sale} against the hand-computed value.
    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed {ret,sale}=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        if1.w100 = 1'b0; if1.btn = 1'b0;
        if2.w100 = 1'b0; if2.btn = 1'b0;

        // Reset held two cycles with coins offered.
        RSTn = 1'b0;
        step1(1'b1, 1'b0); chk("rst_c1", {if1.ret, if1.sale}, 2'b00);
        step1(1'b1, 1'b0); chk("rst_c2", {if1.ret, if1.sale}, 2'b00);
        RSTn = 1'b1;
        step1(1'b0, 1'b1); chk("rst_btn_nocredit", {if1.ret, if1.sale}, 2'b00);
        step1(1'b0, 1'b0); chk("rst_idle", {if1.ret, if1.sale}, 2'b00);

        // Underpay refund.
        step1(1'b1, 1'b0); chk("under_coin", {if1.ret, if1.sale}, 2'b00);
        step1(1'b0, 1'b1); chk("under_refund", {if1.ret, if1.sale}, 2'b10);
        step1(1'b0, 1'b0); chk("under_after", {if1.ret, if1.sale}, 2'b00);
        step1(1'b0, 1'b1); chk("under_btn_again", {if1.ret, if1.sale}, 2'b00);

        // Exact payment.
        step1(1'b1, 1'b0); chk("exact_c1", {if1.ret, if1.sale}, 2'b00);
        step1(1'b1, 1'b0); chk("exact_c2", {if1.ret, if1.sale}, 2'b00);
        step1(1'b0, 1'b1); chk("exact_sale", {if1.ret, if1.sale}, 2'b01);
        step1(1'b0, 1'b0); chk("exact_after", {if1.ret, if1.sale}, 2'b00);
        step1(1'b0, 1'b1); chk("exact_cleared", {if1.ret, if1.sale}, 2'b00);

        // Overpay with one unit of change.
        step1(1'b1, 1'b0); chk("over_c1", {if1.ret, if1.sale}, 2'b00);
        step1(1'b1, 1'b0); chk("over_c2", {if1.ret, if1.sale}, 2'b00);
        step1(1'b1, 1'b0); chk("over_c3", {if1.ret, if1.sale}, 2'b00);
        step1(1'b0, 1'b1); chk("over_sale_ret", {if1.ret, if1.sale}, 2'b11);
        step1(1'b0, 1'b0); chk("over_after1", {if1.ret, if1.sale}, 2'b00);
        step1(1'b0, 1'b0); chk("over_after2", {if1.ret, if1.sale}, 2'b00);

        // Gapped coins, exact payment.
        step1(1'b1, 1'b0); step1(1'b0, 1'b0); step1(1'b1, 1'b0);
        chk("gap_coins", {if1.ret, if1.sale}, 2'b00);
        step1(1'b0, 1'b1); chk("gap_sale", {if1.ret, if1.sale}, 2'b01);
        step1(1'b0, 1'b0); chk("gap_after", {if1.ret, if1.sale}, 2'b00);

        // Saturation: fourth coin is ignored at the ceiling.
        step1(1'b0, 1'b0); step1(1'b1, 1'b0); step1(1'b0, 1'b0);
        step1(1'b1, 1'b0); step1(1'b1, 1'b0); step1(1'b1, 1'b0);
        chk("sat_coins", {if1.ret, if1.sale}, 2'b00);
        step1(1'b0, 1'b1); chk("sat_sale_ret", {if1.ret, if1.sale}, 2'b11);
        step1(1'b0, 1'b0); chk("sat_after", {if1.ret, if1.sale}, 2'b00);
        step1(1'b0, 1'b1); chk("sat_cleared", {if1.ret, if1.sale}, 2'b00);

        // Coin together with the button is not credited.
        step1(1'b1, 1'b0); chk("simul_coin", {if1.ret, if1.sale}, 2'b00);
        step1(1'b1, 1'b1); chk("simul_refund", {if1.ret, if1.sale}, 2'b10);
        step1(1'b0, 1'b1); chk("simul_cleared", {if1.ret, if1.sale}, 2'b00);
        step1(1'b0, 1'b0);

        // Second instance: 5 coins plus one over the ceiling, 3 units of change.
        for (int i = 0; i < 6; i++) begin
            step2(1'b1, 1'b0);
            chk("ret_coin", {if2.ret, if2.sale}, 2'b00);
        end
        step2(1'b0, 1'b1); chk("ret_sale", {if2.ret, if2.sale}, 2'b11);
        step2(1'b1, 1'b1); chk("ret_unit2", {if2.ret, if2.sale}, 2'b10);
        step2(1'b0, 1'b0); chk("ret_unit3", {if2.ret, if2.sale}, 2'b10);
        step2(1'b0, 1'b0); chk("ret_done", {if2.ret, if2.sale}, 2'b00);
        step2(1'b0, 1'b1); chk("ret_coin_ignored", {if2.ret, if2.sale}, 2'b00);

        // Reset in the middle of a payout abandons it.
        for (int i = 0; i < 5; i++) begin
            step2(1'b1, 1'b0);
        end
        step2(1'b0, 1'b1); chk("mid_sale", {if2.ret, if2.sale}, 2'b11);
        RSTn = 1'b0;
        step2(1'b0, 1'b0); chk("mid_rst", {if2.ret, if2.sale}, 2'b00);
        RSTn = 1'b1;
        step2(1'b0, 1'b0); chk("mid_post1", {if2.ret, if2.sale}, 2'b00);
        step2(1'b0, 1'b1); chk("mid_post_btn", {if2.ret, if2.sale}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
